cpu_run_checker: RTL and testbench

- Synthesizable run-and-check harness that sits beside the single-cycle CPU core.
- Runs the core for a programmable cycle budget and captures a circular PC/instruction trace.
- Snoops register-file writes into NCHK shadow slots, then compares them against programmed expected values and reports pass/fail plus a per-slot error mask.
- Replaces ad-hoc per-program register checks with one configurable block usable in simulation and on board.

---
 rtl/cpu_run_checker.sv | 156 +++++++++++++++
 tb/tb_cpu_run_checker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_checker.sv
// Run-and-check harness for the single-cycle CPU: runs the core for a cycle budget,
// keeps a circular PC/instruction trace and checks snooped register writes against expected values.
module cpu_run_checker #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned NCHK    = 6,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned IDX_W  = (NCHK > 1) ? $clog2(NCHK) : 1,
    localparam int unsigned TC_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CNT_W-1:0]          run_cycles,
    input  logic [PC_W-1:0]           pc,
    input  logic [INSTR_W-1:0]        instruction,
    input  logic                      reg_we,
    input  logic [4:0]                reg_waddr,
    input  logic [DATA_W-1:0]         reg_wdata,
    input  logic                      cfg_we,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic                      cfg_en,
    input  logic [4:0]                cfg_addr,
    input  logic [DATA_W-1:0]         cfg_val,
    input  logic                      tr_rd,
    output logic [PC_W+INSTR_W-1:0]   tr_data,
    output logic [TC_W-1:0]           tr_count,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [NCHK-1:0]           err_mask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned TR_W  = PC_W + INSTR_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     budget;
    logic [IDX_W-1:0]     chk_idx;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [TR_W-1:0]      mem [DEPTH];

    logic                 slot_en   [NCHK];
    logic [4:0]           slot_addr [NCHK];
    logic [DATA_W-1:0]    slot_val  [NCHK];
    logic [DATA_W-1:0]    shadow    [NCHK];

    logic                 start_ok, cfg_ok, push_ok, pop_ok, chk_ok;
    logic [NCHK-1:0]      err_mask_n;

    // Next-state and per-cycle strobes
    always_comb begin
        state_n    = state;
        start_ok   = 1'b0;
        cfg_ok     = 1'b0;
        push_ok    = 1'b0;
        pop_ok     = 1'b0;
        chk_ok     = 1'b0;
        err_mask_n = err_mask;
        case (state)
            S_IDLE, S_DONE: begin
                cfg_ok = cfg_we && (32'(cfg_idx) < NCHK);
                if (start) begin
                    start_ok   = 1'b1;
                    err_mask_n = '0;
                    state_n    = (run_cycles == '0) ? S_CHECK : S_RUN;
                end else begin
                    pop_ok = (state == S_DONE) && tr_rd && (tr_count != '0);
                end
            end
            S_RUN: begin
                push_ok = 1'b1;
                if (CNT_W'(cycle_cnt + CNT_W'(1)) == budget) state_n = S_CHECK;
            end
            S_CHECK: begin
                chk_ok = 1'b1;
                if (slot_en[chk_idx] && (shadow[chk_idx] != slot_val[chk_idx]))
                    err_mask_n[chk_idx] = 1'b1;
                if (chk_idx == IDX_W'(NCHK - 1)) state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, counters, slot configuration and shadows
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_mask  <= '0;
            budget    <= '0;
            cycle_cnt <= '0;
            chk_idx   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tr_count  <= '0;
            for (int i = 0; i < NCHK; i++) begin
                slot_en[i]   <= 1'b0;
                slot_addr[i] <= '0;
                slot_val[i]  <= '0;
                shadow[i]    <= '0;
            end
        end else begin
            state    <= state_n;
            busy     <= (state_n == S_RUN) || (state_n == S_CHECK);
            done     <= (state_n == S_DONE);
            pass     <= (state_n == S_DONE) && (err_mask_n == '0);
            err_mask <= err_mask_n;
            if (cfg_ok) begin
                slot_en[cfg_idx]   <= cfg_en;
                slot_addr[cfg_idx] <= cfg_addr;
                slot_val[cfg_idx]  <= cfg_val;
            end
            if (start_ok) begin
                budget    <= run_cycles;
                cycle_cnt <= '0;
                chk_idx   <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                tr_count  <= '0;
                for (int i = 0; i < NCHK; i++) shadow[i] <= '0;
            end
            if (push_ok) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
                wr_ptr    <= wr_ptr + PTR_W'(1);
                // A full trace drops its oldest entry so the newest DEPTH remain
                if (tr_count == TC_W'(DEPTH)) rd_ptr <= rd_ptr + PTR_W'(1);
                else                          tr_count <= tr_count + TC_W'(1);
                if (reg_we && (reg_waddr != 5'd0)) begin
                    for (int i = 0; i < NCHK; i++)
                        if (slot_en[i] && (slot_addr[i] == reg_waddr)) shadow[i] <= reg_wdata;
                end
            end
            if (chk_ok) chk_idx <= chk_idx + IDX_W'(1);
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                tr_count <= tr_count - TC_W'(1);
            end
        end
    end

    // Trace storage needs no reset: tr_count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {pc, instruction};
    end

    assign tr_data = (tr_count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_cpu_run_checker.sv
// Scoreboard bench for cpu_run_checker: directed plan scenarios plus randomized runs
// checked against a last-write-per-register / last-DEPTH-trace reference model.
module tb_cpu_run_checker;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned NCHK    = 6;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned IDX_W   = $clog2(NCHK);
    localparam int unsigned TC_W    = $clog2(DEPTH + 1);

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic [CNT_W-1:0]          run_cycles;
    logic [PC_W-1:0]           pc;
    logic [INSTR_W-1:0]        instruction;
    logic                      reg_we;
    logic [4:0]                reg_waddr;
    logic [DATA_W-1:0]         reg_wdata;
    logic                      cfg_we;
    logic [IDX_W-1:0]          cfg_idx;
    logic                      cfg_en;
    logic [4:0]                cfg_addr;
    logic [DATA_W-1:0]         cfg_val;
    logic                      tr_rd;
    logic [PC_W+INSTR_W-1:0]   tr_data;
    logic [TC_W-1:0]           tr_count;
    logic [CNT_W-1:0]          cycle_cnt;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [NCHK-1:0]           err_mask;

    cpu_run_checker dut (
        .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
        .pc(pc), .instruction(instruction), .reg_we(reg_we), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_addr(cfg_addr), .cfg_val(cfg_val), .tr_rd(tr_rd), .tr_data(tr_data),
        .tr_count(tr_count), .cycle_cnt(cycle_cnt), .busy(busy), .done(done),
        .pass(pass), .err_mask(err_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             pass;
        logic [NCHK-1:0]  mask;
        int               cyc;
        int               cnt;
    } run_exp_t;

    typedef struct {
        logic [63:0] data;
        int          cnt;
    } tr_exp_t;

    run_exp_t    exp_run_q[$];
    tr_exp_t     exp_tr_q[$];

    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model state
    bit          m_en   [NCHK];
    int          m_addr [NCHK];
    logic [31:0] m_val  [NCHK];
    logic [31:0] last_w [32];
    logic [63:0] tq[$];
    int          sched_a[int];
    logic [31:0] sched_d[int];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result or a trace entry
    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            done_q = 1'b0;
        end else begin
            if (done && !done_q) begin
                if (exp_run_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    run_exp_t e;
                    e = exp_run_q.pop_front();
                    check("pass", 64'(pass), 64'(e.pass));
                    check("err_mask", 64'(err_mask), 64'(e.mask));
                    check("cycle_cnt", 64'(cycle_cnt), 64'(e.cyc));
                    check("tr_count_done", 64'(tr_count), 64'(e.cnt));
                end
            end
            if (done && tr_rd && exp_tr_q.size() != 0) begin
                tr_exp_t t;
                t = exp_tr_q.pop_front();
                check("tr_data", 64'(tr_data), t.data);
                check("tr_count_pop", 64'(tr_count), 64'(t.cnt));
            end
            done_q = done;
        end
    end

    function automatic int pick_addr();
        case ($urandom_range(0, 5))
            0:       return 0;
            5:       return int'($urandom_range(0, 31));
            default: return 15 + int'($urandom_range(1, 4));
        endcase
    endfunction

    task automatic cfg(input int idx, input bit en, input int addr, input logic [31:0] val);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_en = en; cfg_addr = 5'(addr); cfg_val = val;
        if (idx < int'(NCHK)) begin
            m_en[idx] = en; m_addr[idx] = addr; m_val[idx] = val;
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NCHK); i++) begin
            m_en[i] = 1'b0; m_addr[i] = 0; m_val[i] = '0;
        end
        tq.delete();
    endtask

    // One run; abort_at >= 0 pulls reset low after that many RUN edges
    task automatic run(input int n, input bit rnd, input bit cfg_in_run, input int abort_at);
        run_exp_t e;
        int waited;
        for (int r = 0; r < 32; r++) last_w[r] = '0;
        tq.delete();
        @(posedge clk); #1;
        start = 1'b1; run_cycles = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (c == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_done", 64'(done), 64'(0));
                check("abort_tr_count", 64'(tr_count), 64'(0));
                check("abort_cycle_cnt", 64'(cycle_cnt), 64'(0));
                model_reset();
                reg_we = 1'b0; cfg_we = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                return;
            end
            if (c == 0) check("run_busy", 64'(busy), 64'(1));
            pc = 32'(4 * c);
            instruction = $urandom;
            reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
            if (sched_a.exists(c)) begin
                reg_we = 1'b1; reg_waddr = 5'(sched_a[c]); reg_wdata = sched_d[c];
            end else if (rnd && $urandom_range(0, 2) == 0) begin
                reg_we = 1'b1; reg_waddr = 5'(pick_addr()); reg_wdata = 32'($urandom_range(0, 3));
            end
            cfg_we = cfg_in_run && (c == 1);
            cfg_idx = '0; cfg_en = 1'b1; cfg_addr = 5'd5; cfg_val = 32'd123;
            if (reg_we && reg_waddr != 5'd0) last_w[reg_waddr] = reg_wdata;
            tq.push_back({pc, instruction});
            if (tq.size() > DEPTH) void'(tq.pop_front());
            @(posedge clk);
            #1;
        end
        reg_we = 1'b0; cfg_we = 1'b0;
        e.mask = '0;
        for (int i = 0; i < int'(NCHK); i++) begin
            logic [31:0] sh;
            sh = (m_addr[i] == 0) ? 32'd0 : last_w[m_addr[i]];
            if (m_en[i] && sh != m_val[i]) e.mask[i] = 1'b1;
        end
        e.pass = (e.mask == '0);
        e.cyc  = n;
        e.cnt  = tq.size();
        exp_run_q.push_back(e);
        waited = 0;
        while (!done && waited < int'(NCHK) + 4) begin
            @(negedge clk);
            waited++;
        end
        check("check_latency", 64'(waited), 64'(NCHK + 1));
    endtask

    task automatic pops(input int k);
        for (int i = 0; i < k; i++) begin
            tr_exp_t t;
            @(posedge clk); #1;
            tr_rd = 1'b1;
            t.cnt = tq.size();
            t.data = (tq.size() != 0) ? tq.pop_front() : 64'd0;
            exp_tr_q.push_back(t);
        end
        @(posedge clk); #1;
        tr_rd = 1'b0;
    endtask

    task automatic base_sched();
        sched_a.delete(); sched_d.delete();
        sched_a[2] = 16; sched_d[2] = 32'd5;
        sched_a[4] = 17; sched_d[4] = 32'd5;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; run_cycles = '0; pc = '0; instruction = '0;
        reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_en = 1'b0; cfg_addr = '0; cfg_val = '0; tr_rd = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_pass", 64'(pass), 64'(0));
        check("rst_err_mask", 64'(err_mask), 64'(0));
        check("rst_tr_count", 64'(tr_count), 64'(0));
        check("rst_cycle_cnt", 64'(cycle_cnt), 64'(0));
        check("rst_tr_data", 64'(tr_data), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;

        // Mid-run reset drops the configuration; a follow-up run must then pass
        cfg(0, 1, 16, 32'd5); cfg(1, 1, 17, 32'd5); cfg(2, 1, 19, 32'd10); cfg(3, 1, 18, 32'd0);
        sched_a.delete(); sched_d.delete();
        run(17, 0, 0, 5);
        run(3, 0, 0, -1);

        // Passing run; cfg_we during RUN must not disturb slot 0
        cfg(0, 1, 16, 32'd5); cfg(1, 1, 17, 32'd5); cfg(2, 1, 19, 32'd10); cfg(3, 1, 18, 32'd0);
        base_sched(); sched_a[6] = 19; sched_d[6] = 32'd10;
        run(17, 0, 1, -1);

        // Late fix on the final RUN edge is captured
        base_sched(); sched_a[3] = 19; sched_d[3] = 32'd9; sched_a[16] = 19; sched_d[16] = 32'd10;
        run(17, 0, 0, -1);

        // Stale value leaves slot 2 in error
        base_sched(); sched_a[3] = 19; sched_d[3] = 32'd9;
        run(17, 0, 0, -1);

        // $0 slot and disabled slot never error
        cfg(4, 1, 0, 32'd0); cfg(5, 0, 20, 32'd99);
        base_sched(); sched_a[6] = 19; sched_d[6] = 32'd10;
        sched_a[1] = 0; sched_d[1] = 32'd7; sched_a[8] = 20; sched_d[8] = 32'd1;
        run(17, 0, 0, -1);

        // Trace wrap and drain, including a pop when empty
        sched_a.delete(); sched_d.delete();
        run(20, 0, 0, -1);
        pops(17);
        @(negedge clk);
        check("empty_tr_data", 64'(tr_data), 64'(0));
        check("empty_tr_count", 64'(tr_count), 64'(0));

        // Zero budget goes straight to CHECK
        run(0, 0, 0, -1);

        // Randomized runs
        sched_a.delete(); sched_d.delete();
        for (int it = 0; it < 14; it++) begin
            int nc;
            nc = int'($urandom_range(0, 3));
            for (int k = 0; k < nc; k++)
                cfg(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick_addr(),
                    32'($urandom_range(0, 3)));
            run(int'($urandom_range(0, 25)), 1, 1'($urandom_range(0, 1)), -1);
            pops(int'($urandom_range(0, DEPTH + 2)));
        end

        repeat (3) @(negedge clk);
        check("drain_run_q", 64'(exp_run_q.size()), 64'(0));
        check("drain_tr_q", 64'(exp_tr_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
